linear_feedback_shift_register: RTL and testbench



---
 rtl/linear_feedback_shift_register.sv | 74 +++++++
 tb/tb_linear_feedback_shift_register.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/linear_feedback_shift_register.sv
// Fibonacci-form LFSR with run-time seed load, zero-seed protection and
// a one-cycle wrap pulse whenever stepping returns to the period start value.
module linear_feedback_shift_register #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'('hB8),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'('h01)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state,
  output logic             bit_out,
  output logic             wrap,
  output logic             load_err
);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;
  logic             fb;
  logic [WIDTH-1:0] step_val;

  // Feedback bit and the candidate next value for a step.
  always_comb begin
    fb       = ^(state_q & TAPS);
    step_val = {state_q[WIDTH-2:0], fb};
  end

  // Next-state selection: load beats en beats hold; pulses default low.
  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (seed_in != '0) begin
        state_d = seed_in;
        start_d = seed_in;
      end else begin
        // All-zero seed would lock the register; substitute the default.
        state_d    = SEED;
        start_d    = SEED;
        load_err_d = 1'b1;
      end
    end else if (en) begin
      state_d = step_val;
      wrap_d  = (step_val == start_q);
    end
  end

  // State, period start and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEED;
      start_q    <= SEED;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign state    = state_q;
  assign bit_out  = state_q[WIDTH-1];
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_linear_feedback_shift_register.sv
// Self-checking bench for linear_feedback_shift_register (default parameters).
module tb_linear_feedback_shift_register;

  localparam int unsigned W    = 8;
  localparam int unsigned TAPS = 32'hB8;
  localparam int unsigned SEED = 32'h01;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] seed_in = '0;
  logic [W-1:0] state;
  logic         bit_out;
  logic         wrap;
  logic         load_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model variables (plain integers).
  int m_state;
  int m_start;
  int m_wrap;
  int m_lerr;
  int seen [256];

  linear_feedback_shift_register #(
    .WIDTH (W),
    .TAPS  (8'hB8),
    .SEED  (8'h01)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (load),
    .seed_in  (seed_in),
    .state    (state),
    .bit_out  (bit_out),
    .wrap     (wrap),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Next value by counting tapped ones and appending their parity as the new LSB.
  function automatic int ref_next(input int s);
    int ones = 0;
    for (int i = 0; i < int'(W); i++)
      if (((TAPS >> i) & 1) != 0 && ((s >> i) & 1) != 0) ones++;
    return (s * 2 + (ones % 2)) % 256;
  endfunction

  task automatic model_reset();
    m_state = SEED;
    m_start = SEED;
    m_wrap  = 0;
    m_lerr  = 0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".state"}, int'(state), m_state);
    check_eq({tag, ".bit_out"}, int'(bit_out), (m_state >> 7) & 1);
    check_eq({tag, ".wrap"}, int'(wrap), m_wrap);
    check_eq({tag, ".load_err"}, int'(load_err), m_lerr);
  endtask

  // Apply one cycle of inputs, advance the model, check #1 after the edge.
  task automatic do_cycle(input string tag, input logic e, input logic l, input logic [W-1:0] s);
    int nxt;
    en = e;
    load = l;
    seed_in = s;
    @(posedge clk);
    m_wrap = 0;
    m_lerr = 0;
    if (l) begin
      if (s != 0) begin
        m_state = int'(s);
        m_start = int'(s);
      end else begin
        m_state = SEED;
        m_start = SEED;
        m_lerr  = 1;
      end
    end else if (e) begin
      nxt = ref_next(m_state);
      m_wrap = (nxt == m_start) ? 1 : 0;
      m_state = nxt;
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    int exp_seq [5];
    exp_seq[0] = 8'h02; exp_seq[1] = 8'h04; exp_seq[2] = 8'h08;
    exp_seq[3] = 8'h11; exp_seq[4] = 8'h23;

    // Asynchronous reset with no clock edge.
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst.state", int'(state), 8'h01);
    check_eq("rst.bit_out", int'(bit_out), 0);
    check_eq("rst.wrap", int'(wrap), 0);
    check_eq("rst.load_err", int'(load_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic stepping against the known sequence.
    for (int i = 0; i < 5; i++) begin
      do_cycle("step", 1'b1, 1'b0, '0);
      check_eq("step.seq", int'(state), exp_seq[i]);
    end
    for (int i = 0; i < 3; i++) begin
      do_cycle("hold", 1'b0, 1'b0, '0);
      check_eq("hold.val", int'(state), 8'h23);
    end

    // Seed load, a step from it, and load priority over en.
    do_cycle("load_a5", 1'b0, 1'b1, 8'hA5);
    check_eq("load_a5.val", int'(state), 8'hA5);
    check_eq("load_a5.bit", int'(bit_out), 1);
    do_cycle("step_a5", 1'b1, 1'b0, '0);
    check_eq("step_a5.val", int'(state), 8'h4A);
    do_cycle("load_en", 1'b1, 1'b1, 8'h3C);
    check_eq("load_en.val", int'(state), 8'h3C);
    check_eq("load_en.wrap", int'(wrap), 0);

    // Zero-load protection, then a full period from the substituted seed.
    do_cycle("zload", 1'b0, 1'b1, 8'h00);
    check_eq("zload.val", int'(state), 8'h01);
    check_eq("zload.err", int'(load_err), 1);
    for (int k = 1; k <= 255; k++) begin
      do_cycle("zper", 1'b1, 1'b0, '0);
      check_eq("zper.wrap_pos", int'(wrap), (k == 255) ? 1 : 0);
      if (k == 1) check_eq("zload.err_gone", int'(load_err), 0);
    end

    // Full period from reset: every non-zero value exactly once per period.
    @(negedge clk);
    rst_n = 1'b0;
    #1 model_reset();
    check_outputs("rst2");
    @(negedge clk);
    rst_n = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int v = 0; v < 256; v++) seen[v] = 0;
      for (int k = 1; k <= 255; k++) begin
        do_cycle("per", 1'b1, 1'b0, '0);
        seen[int'(state)]++;
        check_eq("per.wrap_pos", int'(wrap), (k == 255) ? 1 : 0);
      end
      check_eq("per.zero_seen", seen[0], 0);
      for (int v = 1; v < 256; v++)
        if (seen[v] != 1) check_eq("per.unique", seen[v], 1);
      n_tests++;
    end

    // Asynchronous reset dropped between edges while stepping.
    for (int i = 0; i < 7; i++) do_cycle("pre", 1'b1, 1'b0, '0);
    do_cycle("pre_load", 1'b0, 1'b0, '0);
    do_cycle("zpulse", 1'b0, 1'b1, 8'h00);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_eq("arst.state", int'(state), 8'h01);
    check_eq("arst.wrap", int'(wrap), 0);
    check_eq("arst.load_err", int'(load_err), 0);
    #1 rst_n = 1'b1;
    do_cycle("arst.step", 1'b1, 1'b0, '0);
    check_eq("arst.restart", int'(state), 8'h02);

    // Randomised mix of load / step / hold against the model.
    for (int i = 0; i < 3000; i++) begin
      logic e, l;
      logic [W-1:0] s;
      e = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
      do_cycle("rnd", e, l, s);
      check_eq("rnd.nonzero", (state != 0) ? 1 : 0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
